// File: rtl/note_scroller.sv
// Seven-lane falling-note scroller: pending spawns enter at the top (bit 191), maps shift
// toward the hit line (bit 0) every SCROLL_DIV clocks, and hits/misses are scored at the bottom.
// Optional build macro: NOTE_SCROLLER_PAUSE_EN adds a `pause` input that freezes scrolling.
module note_scroller #(
  parameter int SCROLL_DIV = 100000,
  parameter int HIT_WIN    = 8
) (
  input  logic         clk,
  input  logic         rst,
`ifdef NOTE_SCROLLER_PAUSE_EN
  input  logic         pause,
`endif
  input  logic         note_valid,
  input  logic [2:0]   note_lane,
  output logic         note_ready,
  input  logic [6:0]   hit,
  output logic [191:0] notesMap0,
  output logic [191:0] notesMap1,
  output logic [191:0] notesMap2,
  output logic [191:0] notesMap3,
  output logic [191:0] notesMap4,
  output logic [191:0] notesMap5,
  output logic [191:0] notesMap6,
  output logic [6:0]   hit_pulse,
  output logic [6:0]   miss_pulse,
  output logic [15:0]  score,
  output logic [15:0]  miss_cnt
);

  localparam int NUM_LANES = 7;
  localparam int MAP_W     = 192;
  localparam int DIV_W     = (SCROLL_DIV > 2) ? $clog2(SCROLL_DIV) : 1;

  // Spawn handshake: a request transfers in any cycle where note_valid && note_ready
  // are both high at the rising edge; note_ready is combinational from the pending
  // flag of the requested lane and never depends on note_valid.

  logic [DIV_W-1:0]                    div_q, div_d;
  logic [NUM_LANES-1:0]                pend_q, pend_d;
  logic [NUM_LANES-1:0][MAP_W-1:0]     map_q, map_d;
  logic [NUM_LANES-1:0]                hit_pulse_q, hit_pulse_d;
  logic [NUM_LANES-1:0]                miss_pulse_q, miss_pulse_d;
  logic [15:0]                         score_q, score_d;
  logic [15:0]                         miss_cnt_q, miss_cnt_d;

  logic                                tick;
  logic                                freeze;
  logic                                spawn;
  logic [NUM_LANES:0]                  pend_ext;
  logic [NUM_LANES-1:0]                hit_ok;
  logic [NUM_LANES-1:0]                miss;
  logic [NUM_LANES-1:0][MAP_W-1:0]     map_hit;
  logic [3:0]                          hit_cnt;
  logic [3:0]                          miss_cnt_inc;

`ifdef NOTE_SCROLLER_PAUSE_EN
  assign freeze = pause;
`else
  assign freeze = 1'b0;
`endif

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {13'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Lane 7 does not exist; the extra always-set flag makes it permanently not ready.
  assign pend_ext   = {1'b1, pend_q};
  assign note_ready = ~pend_ext[note_lane];
  assign spawn      = note_valid & note_ready;

  // Per-lane hit evaluation on the pre-shift map: clear the lowest set bit in the window.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [HIT_WIN-1:0] win;
    logic [HIT_WIN-1:0] low;
    assign win        = map_q[g][HIT_WIN-1:0];
    assign low        = win & (~win + 1'b1);
    assign hit_ok[g]  = hit[g] & (|win);
    assign map_hit[g] = hit_ok[g] ? (map_q[g] & ~MAP_W'(low)) : map_q[g];
  end

  always_comb begin
    tick         = 1'b0;
    div_d        = div_q;
    pend_d       = pend_q;
    map_d        = map_hit;
    miss         = '0;
    hit_cnt      = '0;
    miss_cnt_inc = '0;

    if (!freeze) begin
      if (div_q == DIV_W'(SCROLL_DIV - 1)) begin
        tick  = 1'b1;
        div_d = '0;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    if (tick) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        miss[l]  = map_hit[l][0];
        map_d[l] = {pend_q[l], map_hit[l][MAP_W-1:1]};
      end
      pend_d = '0;
    end

    // A spawn landing on a tick edge stays pending for the following tick.
    if (spawn) begin
      pend_d[note_lane] = 1'b1;
    end

    for (int l = 0; l < NUM_LANES; l++) begin
      hit_cnt      = hit_cnt + {3'b0, hit_ok[l]};
      miss_cnt_inc = miss_cnt_inc + {3'b0, miss[l]};
    end

    hit_pulse_d  = hit_ok;
    miss_pulse_d = miss;
    score_d      = sat_add(score_q, hit_cnt);
    miss_cnt_d   = sat_add(miss_cnt_q, miss_cnt_inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= '0;
      pend_q       <= '0;
      map_q        <= '0;
      hit_pulse_q  <= '0;
      miss_pulse_q <= '0;
      score_q      <= '0;
      miss_cnt_q   <= '0;
    end else begin
      div_q        <= div_d;
      pend_q       <= pend_d;
      map_q        <= map_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
      score_q      <= score_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign notesMap0  = map_q[0];
  assign notesMap1  = map_q[1];
  assign notesMap2  = map_q[2];
  assign notesMap3  = map_q[3];
  assign notesMap4  = map_q[4];
  assign notesMap5  = map_q[5];
  assign notesMap6  = map_q[6];
  assign hit_pulse  = hit_pulse_q;
  assign miss_pulse = miss_pulse_q;
  assign score      = score_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_note_scroller.sv
// Directed bench for note_scroller with SCROLL_DIV=4, HIT_WIN=8; expected values are
// hand-derived from note entry ticks (note at bit 191-(k-E) after tick k).
module tb_note_scroller;

  logic         clk;
  logic         rst;
  logic         note_valid;
  logic [2:0]   note_lane;
  logic         note_ready;
  logic [6:0]   hit;
  logic [191:0] notesMap0, notesMap1, notesMap2, notesMap3, notesMap4, notesMap5, notesMap6;
  logic [6:0]   hit_pulse;
  logic [6:0]   miss_pulse;
  logic [15:0]  score;
  logic [15:0]  miss_cnt;
`ifdef NOTE_SCROLLER_PAUSE_EN
  logic         pause;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [191:0] one;
  logic [191:0] maps [7];

  note_scroller #(.SCROLL_DIV(4), .HIT_WIN(8)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef NOTE_SCROLLER_PAUSE_EN
    .pause      (pause),
`endif
    .note_valid (note_valid),
    .note_lane  (note_lane),
    .note_ready (note_ready),
    .hit        (hit),
    .notesMap0  (notesMap0),
    .notesMap1  (notesMap1),
    .notesMap2  (notesMap2),
    .notesMap3  (notesMap3),
    .notesMap4  (notesMap4),
    .notesMap5  (notesMap5),
    .notesMap6  (notesMap6),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .score      (score),
    .miss_cnt   (miss_cnt)
  );

  assign maps[0] = notesMap0;
  assign maps[1] = notesMap1;
  assign maps[2] = notesMap2;
  assign maps[3] = notesMap3;
  assign maps[4] = notesMap4;
  assign maps[5] = notesMap5;
  assign maps[6] = notesMap6;

  // Clock / reset-relative cycle counter (tracks the scroll divider phase).
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ready_chk(input string tag, input logic [2:0] lane, input logic exp);
    note_lane = lane;
    #1;
    chk(tag, {191'b0, note_ready}, {191'b0, exp});
  endtask

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic spawn(input logic [2:0] lane);
    note_valid = 1'b1;
    note_lane  = lane;
  endtask

  initial begin
    one        = 192'd1;
    rst        = 1'b1;
    note_valid = 1'b0;
    note_lane  = 3'd0;
    hit        = 7'b0;
`ifdef NOTE_SCROLLER_PAUSE_EN
    pause      = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Reset state
    for (int l = 0; l < 7; l++) chk($sformatf("rst_map%0d", l), maps[l], '0);
    chk("rst_score", score, '0);
    chk("rst_miss_cnt", miss_cnt, '0);
    chk("rst_hit_pulse", hit_pulse, '0);
    chk("rst_miss_pulse", miss_pulse, '0);
    for (int l = 0; l < 7; l++) ready_chk($sformatf("rst_ready%0d", l), 3'(l), 1'b1);
    ready_chk("ready_lane7", 3'd7, 1'b0);

    rst = 1'b0;
    spawn(3'd2);                                   // cyc 0 -> enters tick 1
    goto(1);
    note_valid = 1'b0;
    ready_chk("ready_pend2", 3'd2, 1'b0);
    spawn(3'd0);
    goto(2);
    spawn(3'd6);
    goto(3);
    note_valid = 1'b0;
    ready_chk("ready_pend2_b", 3'd2, 1'b0);
    ready_chk("ready4_free", 3'd4, 1'b1);
    spawn(3'd4);                                   // tick cycle -> enters tick 2
    goto(4);
    note_valid = 1'b0;
    chk("t1_map2", notesMap2, one << 191);
    chk("t1_map0", notesMap0, one << 191);
    chk("t1_map6", notesMap6, one << 191);
    chk("t1_map4", notesMap4, '0);
    ready_chk("t1_ready2", 3'd2, 1'b1);
    ready_chk("t1_ready4", 3'd4, 1'b0);
    goto(8);
    chk("t2_map4", notesMap4, one << 191);
    chk("t2_map2", notesMap2, one << 190);
    ready_chk("t2_ready4", 3'd4, 1'b1);

    goto(21); spawn(3'd1);                         // E=6
    goto(22); spawn(3'd5);                         // E=6
    goto(23); spawn(3'd3);                         // tick cycle, E=7
    goto(24); note_valid = 1'b0;
    goto(27); spawn(3'd2);                         // tick cycle, E=8
    goto(28); note_valid = 1'b0;
    goto(31); spawn(3'd4);                         // tick cycle, E=9
    goto(32); note_valid = 1'b0;

    // After tick 189
    goto(756);
    chk("t189_map2", notesMap2, (one << 3) | (one << 10));
    chk("t189_map0", notesMap0, one << 3);
    chk("t189_map1", notesMap1, one << 8);
    chk("t189_map4", notesMap4, (one << 4) | (one << 11));
    hit = 7'b0000100;
    goto(757);
    hit = 7'b0000010;
    chk("hit2_map2", notesMap2, one << 10);
    chk("hit2_pulse", hit_pulse, 7'b0000100);
    chk("hit2_score", score, 16'd1);
    goto(758);
    hit = 7'b0;
    chk("hit1_outside_map1", notesMap1, one << 8);
    chk("hit1_outside_pulse", hit_pulse, '0);
    chk("hit1_outside_score", score, 16'd1);

    goto(768);
    chk("t192_map0", notesMap0, one);
    chk("t192_map6", notesMap6, one);
    chk("t192_miss_cnt", miss_cnt, '0);
    goto(772);
    chk("miss_pulse", miss_pulse, 7'b1000001);
    chk("miss_cnt2", miss_cnt, 16'd2);
    chk("miss_map0", notesMap0, '0);
    chk("miss_map6", notesMap6, '0);
    chk("t193_map4", notesMap4, one | (one << 7));
    goto(773);
    chk("miss_pulse_clear", miss_pulse, '0);

    goto(775);
    hit = 7'b0010000;                              // hit in tick cycle
    goto(776);
    hit = 7'b1001100;                              // lanes 2,3 hit, lane 6 empty
    chk("tickhit_pulse", hit_pulse, 7'b0010000);
    chk("tickhit_miss_pulse", miss_pulse, '0);
    chk("tickhit_score", score, 16'd2);
    chk("tickhit_miss_cnt", miss_cnt, 16'd2);
    chk("tickhit_map4", notesMap4, one << 6);
    goto(777);
    hit = 7'b0;
    chk("multi_pulse", hit_pulse, 7'b0001100);
    chk("multi_score", score, 16'd4);
    chk("multi_map3", notesMap3, '0);
    chk("multi_map2", notesMap2, '0);
    dut.score_q <= 16'hFFFE;
    goto(778);
    chk("preload_score", score, 16'hFFFE);
    hit = 7'b0100010;
    goto(779);
    hit = 7'b0010000;
    chk("sat_score", score, 16'hFFFF);
    chk("sat_pulse", hit_pulse, 7'b0100010);
    chk("sat_map1", notesMap1, '0);
    chk("sat_map5", notesMap5, '0);
    goto(780);
    hit = 7'b0;
    chk("sat_hold_score", score, 16'hFFFF);
    chk("sat_hold_pulse", hit_pulse, 7'b0010000);
    chk("sat_hold_map4", notesMap4, '0);
    spawn(3'd6);                                   // enters tick 196
    goto(781);
    note_valid = 1'b0;
    goto(783);
    spawn(3'd0);                                   // tick cycle, stays pending
    goto(784);
    note_valid = 1'b0;
    chk("pre_rst_map6", notesMap6, one << 191);
    ready_chk("pre_rst_ready0", 3'd0, 1'b0);

    // Reset mid-scroll with competing spawn and hits
    rst        = 1'b1;
    note_valid = 1'b1;
    note_lane  = 3'd3;
    hit        = 7'b1111111;
    repeat (2) @(negedge clk);
    for (int l = 0; l < 7; l++) chk($sformatf("mid_rst_map%0d", l), maps[l], '0);
    chk("mid_rst_hit_pulse", hit_pulse, '0);
    chk("mid_rst_miss_pulse", miss_pulse, '0);
    chk("mid_rst_score", score, '0);
    chk("mid_rst_miss_cnt", miss_cnt, '0);
    rst        = 1'b0;
    note_valid = 1'b0;
    hit        = 7'b0;
    ready_chk("post_rst_ready0", 3'd0, 1'b1);
    ready_chk("post_rst_ready3", 3'd3, 1'b1);
    goto(8);
    chk("post_rst_map0", notesMap0, '0);
    chk("post_rst_map3", notesMap3, '0);
    chk("post_rst_map6", notesMap6, '0);
    chk("post_rst_miss_cnt", miss_cnt, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_scroller.md
NOTE_SCROLLER -- requirements
Module: note_scroller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clock port `clk`, reset port `rst`.
REQ-002 SCROLL_DIV, 100000, clk cycles per scroll step (≥2).
REQ-003 HIT_WIN, 8, number of lowest lane positions (bits 0..HIT_WIN-1) in which a hit is accepted (1..32).
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 note_valid  in  1  spawn request valid.
REQ-007 note_lane  in  3  lane of requested note, 0..6.
REQ-008 note_ready  out  1  spawn request accepted this cycle when high together with note_valid.
REQ-009 hit  in  7  one-cycle player hit pulses, one bit per lane.
REQ-010 notesMap0..notesMap6  out  192 each  lane bitmaps for the matrix driver; bit 191 is the spawn (top) position, bit 0 is the hit line.
REQ-011 hit_pulse  out  7  registered one-cycle pulse per lane on a successful hit.
REQ-012 miss_pulse  out  7  registered one-cycle pulse per lane when a note leaves bit 0 unhit.
REQ-013 score  out  16  successful hit count, saturating.
REQ-014 miss_cnt  out  16  missed note count, saturating.

Function
REQ-015 A free-running divider SHALL count 0..SCROLL_DIV-1 and assert an internal tick in the cycle it equals SCROLL_DIV-1, then wrap to 0.
REQ-016 Each lane SHALL hold a 1-bit pending-spawn flag; note_ready SHALL equal NOT pend[note_lane] combinationally; note_lane values 7 SHALL force note_ready low.
REQ-017 On note_valid && note_ready, pend[note_lane] SHALL be set at the next edge.
REQ-018 On tick, each lane map SHALL shift right by one (bit n takes bit n+1), bit 191 SHALL load pend[lane], and all pend flags consumed by the tick SHALL clear.
REQ-019 Spawn accepted in a tick cycle SHALL remain pending and enter bit 191 on the following tick (pend set, not cleared, that edge).
REQ-020 Hit on lane L SHALL, if any of map bits [HIT_WIN-1:0] is 1, clear the lowest-index set bit, pulse hit_pulse[L] next cycle and add 1 to score; otherwise no map change, no pulse.
REQ-021 Hit and tick in the same cycle: hit SHALL be evaluated on the pre-shift map, then the shift applied to the result.
REQ-022 On tick, each lane whose bit 0 is 1 after hit processing SHALL pulse miss_pulse[L] next cycle; miss_cnt SHALL increase by the number of such lanes.
REQ-023 Multiple lanes hit in one cycle SHALL add the popcount of successful hits to score in that cycle.
REQ-024 score and miss_cnt SHALL saturate at 16'hFFFF, never wrapping.
REQ-025 All outputs except note_ready SHALL be registered; map update latency SHALL be one cycle from the tick or hit cycle.

Reset
REQ-026 While rst is high at a clock edge: all maps, pend flags, divider, hit_pulse, miss_pulse, score, miss_cnt SHALL become 0; note_ready SHALL be 1 for lanes 0..6.
REQ-027 rst SHALL take priority over tick, spawn and hit in the same cycle; a reset mid-scroll discards all notes and pending spawns without generating miss pulses.

Configuration
REQ-028 With macro NOTE_SCROLLER_PAUSE_EN defined, an extra input port `pause` (1 bit) SHALL exist; while pause is 1 the divider and shifting SHALL freeze, spawns SHALL still be accepted into pend, and hits SHALL still be evaluated.
REQ-029 Without NOTE_SCROLLER_PAUSE_EN, no pause port SHALL exist and scrolling SHALL never freeze.

Verification (SCROLL_DIV=4, HIT_WIN=8)
REQ-030 Reset, spawn lane 2 -> note_ready low for lane 2 until next tick; after tick notesMap2 = 1<<191; after 191 more ticks notesMap2 = 1.
REQ-031 notesMap2 = 1<<3, hit=7'b0000100 -> next cycle notesMap2 = 0, hit_pulse=7'b0000100, score=1; same hit with notesMap2 = 1<<8 -> no change, score unchanged.
REQ-032 notesMap0 = notesMap6 = 1, tick, no hit -> miss_pulse=7'b1000001, miss_cnt=2, both maps 0.
REQ-033 notesMap4 = 1, hit[4] in tick cycle -> hit_pulse[4]=1, miss_pulse=0, score=1, miss_cnt=0.
REQ-034 Preload score=16'hFFFE, two lanes hit successfully same cycle -> score=16'hFFFF, stays FFFF on further hits.
REQ-035 Spawn accepted in tick cycle, then rst mid-scroll -> all maps 0, miss_cnt unchanged at 0, note_ready=1.
